// File: rtl/fact_pkg.sv
// Definitions shared by the factorial datapath and its binary-to-BCD converter.
package fact_pkg;

  localparam int FACT_W   = 16;
  localparam int BCD_D    = 5;
  localparam int NIBBLE_W = 4;

  typedef enum logic {
    IDLE,
    CONV
  } state_t;

  // True when d decimal digits can represent every w-bit unsigned value.
  function automatic bit bcd_fits(input int w, input int d);
    logic [63:0] pow10;
    pow10 = 64'd1;
    for (int i = 0; i < d; i++) begin
      pow10 = pow10 * 64'd10;
    end
    return pow10 > ((64'd1 << w) - 64'd1);
  endfunction

endpackage

// File: rtl/bcd_adj3.sv
// Double-dabble digit correction: a digit of 5 or more gets 3 added before the shift.
module bcd_adj3
  import fact_pkg::*;
(
  input  logic [NIBBLE_W-1:0] digit_i,
  output logic [NIBBLE_W-1:0] digit_o
);

  assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/fact_bin2bcd.sv
// Serial double-dabble converter for the factorial result, one bit per cycle.
// Define BCD_BLANK_EN to add the registered leading-zero blank[] output.
module fact_bin2bcd
  import fact_pkg::*;
#(
  parameter int W = FACT_W,
  parameter int D = BCD_D
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [W-1:0]          bin_in,
  output logic [NIBBLE_W*D-1:0] bcd_out,
  output logic                  bcd_valid,
  output logic                  busy
`ifdef BCD_BLANK_EN
  ,
  output logic [D-1:0]          blank
`endif
);

  localparam int BW = NIBBLE_W * D;
  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  if (!bcd_fits(W, D)) begin : g_size_check
    $error("fact_bin2bcd: %0d BCD digits cannot hold a %0d-bit value", D, W);
  end

  state_t          state_q, state_d;
  logic            in_valid_q;
  logic            armed_q;
  logic [W-1:0]    shift_q, shift_d;
  logic [BW-1:0]   scratch_q, scratch_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic            valid_q, valid_d;
  logic [BW-1:0]   adj;
  logic [BW+W-1:0] stepped;
  logic            capture;
  logic            done;

  for (genvar g = 0; g < D; g++) begin : g_adj
    bcd_adj3 u_adj3 (
      .digit_i(scratch_q[g*NIBBLE_W +: NIBBLE_W]),
      .digit_o(adj[g*NIBBLE_W +: NIBBLE_W])
    );
  end

  // armed_q stays low until in_valid is seen low, so a level held through reset is not captured.
  assign stepped = {adj, shift_q} << 1;
  assign capture = in_valid & ~in_valid_q & armed_q;
  assign done    = (state_q == CONV) && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      in_valid_q <= 1'b0;
      armed_q    <= 1'b0;
      shift_q    <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      bcd_q      <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_valid_q <= in_valid;
      armed_q    <= armed_q | ~in_valid;
      shift_q    <= shift_d;
      scratch_q  <= scratch_d;
      cnt_q      <= cnt_d;
      bcd_q      <= bcd_d;
      valid_q    <= valid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    valid_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (capture) begin
          shift_d   = bin_in;
          scratch_d = '0;
          cnt_d     = '0;
          state_d   = CONV;
        end
      end
      CONV: begin
        {scratch_d, shift_d} = stepped;
        cnt_d = cnt_q + 1'b1;
        if (done) begin
          bcd_d   = stepped[BW+W-1 -: BW];
          valid_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bcd_out   = bcd_q;
  assign bcd_valid = valid_q;
  assign busy      = (state_q == CONV);

`ifdef BCD_BLANK_EN
  logic [D-1:0] blank_q, blank_d, blank_next;
  logic         upper_zero;

  // Digit 0 is never blanked so a zero result still shows a single 0.
  always_comb begin
    blank_next = '0;
    upper_zero = 1'b1;
    for (int i = D - 1; i >= 1; i--) begin
      upper_zero    = upper_zero & (stepped[W + i*NIBBLE_W +: NIBBLE_W] == '0);
      blank_next[i] = upper_zero;
    end
    blank_d = done ? blank_next : blank_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blank_q <= '0;
    end else begin
      blank_q <= blank_d;
    end
  end

  assign blank = blank_q;
`endif

endmodule

// File: tb/tb_fact_bin2bcd.sv
// Scoreboard bench for fact_bin2bcd; also checks blank[] when BCD_BLANK_EN is defined.
module tb_fact_bin2bcd;

  localparam int W = 16;
  localparam int D = 5;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid;
  logic [W-1:0]   bin_in;
  logic [4*D-1:0] bcd_out;
  logic           bcd_valid;
  logic           busy;
`ifdef BCD_BLANK_EN
  logic [D-1:0]   blank;
`endif

  logic [W-1:0] expQ[$];
  int testsRun    = 0;
  int testsFailed = 0;
  int validPulses = 0;

  fact_bin2bcd #(.W(W), .D(D)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .bin_in   (bin_in),
    .bcd_out  (bcd_out),
    .bcd_valid(bcd_valid),
    .busy     (busy)
`ifdef BCD_BLANK_EN
    ,
    .blank    (blank)
`endif
  );

  always #5 clk = ~clk;

  // Reference conversion by repeated division.
  function automatic logic [4*D-1:0] toBcd(input logic [W-1:0] v);
    logic [4*D-1:0] r;
    int unsigned n;
    r = '0;
    n = v;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return r;
  endfunction

  function automatic logic [D-1:0] blankOf(input logic [4*D-1:0] bcd);
    logic [D-1:0] b;
    bit z;
    b = '0;
    z = 1'b1;
    for (int i = D - 1; i >= 1; i--) begin
      z = z && (bcd[4*i +: 4] == 4'd0);
      b[i] = z;
    end
    return b;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    logic [W-1:0] v;
    if (bcd_valid) begin
      validPulses++;
      if (expQ.size() == 0) begin
        checkOutput("sb_underflow", 32'(bcd_valid), 32'd0);
      end else begin
        v = expQ.pop_front();
        checkOutput("bcd_out", 32'(bcd_out), 32'(toBcd(v)));
`ifdef BCD_BLANK_EN
        checkOutput("blank", 32'(blank), 32'(blankOf(toBcd(v))));
`endif
      end
    end
  end

  task automatic applyStimulus(input logic [W-1:0] value, input bit expectCapture);
    @(negedge clk);
    bin_in   = value;
    in_valid = 1'b1;
    if (expectCapture) expQ.push_back(value);
  endtask

  task automatic waitDone(input bit drop, output int lat, output int busyCycles);
    lat = 0;
    busyCycles = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (busy) busyCycles++;
      if (k == 1 && drop) in_valid = 1'b0;
      if (bcd_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic convertOne(input logic [W-1:0] value);
    int lat, bc;
    applyStimulus(value, 1'b1);
    waitDone(1'b1, lat, bc);
    checkOutput("latency", 32'(lat), 32'd17);
    checkOutput("busy_cycles", 32'(bc), 32'd16);
  endtask

  task automatic heldHigh(input logic [W-1:0] value);
    int start;
    applyStimulus(value, 1'b1);
    start = validPulses;
    repeat (40) @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("held_pulses", 32'(validPulses - start), 32'd1);
  endtask

  task automatic ignoredEdge(input logic [W-1:0] a, input logic [W-1:0] b, input int kRise);
    int start;
    applyStimulus(a, 1'b1);
    start = validPulses;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) in_valid = 1'b0;
      if (k == kRise) begin
        bin_in   = b;
        in_valid = 1'b1;
      end
      if (k == kRise + 1) in_valid = 1'b0;
    end
    checkOutput("ignored_pulses", 32'(validPulses - start), 32'd1);
    checkOutput("ignored_hold", 32'(bcd_out), 32'(toBcd(a)));
  endtask

  task automatic resetMidConv(input logic [W-1:0] value);
    int start;
    applyStimulus(value, 1'b0);
    start = validPulses;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_bcd", 32'(bcd_out), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_valid", 32'(bcd_valid), 32'd0);
    reset = 1'b0;
    repeat (25) @(negedge clk);
    checkOutput("abort_pulses", 32'(validPulses - start), 32'd0);
  endtask

  task automatic resetHeldValid(input logic [W-1:0] value);
    int start, busySeen;
    @(negedge clk);
    reset    = 1'b1;
    bin_in   = value;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    start = validPulses;
    busySeen = 0;
    repeat (25) begin
      @(negedge clk);
      if (busy) busySeen++;
    end
    checkOutput("held_rst_busy", 32'(busySeen), 32'd0);
    checkOutput("held_rst_pulses", 32'(validPulses - start), 32'd0);
    in_valid = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    bin_in   = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_bcd", 32'(bcd_out), 32'd0);
    checkOutput("rst_valid", 32'(bcd_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
`ifdef BCD_BLANK_EN
    checkOutput("rst_blank", 32'(blank), 32'd0);
`endif
    reset = 1'b0;

    convertOne(16'd24);
    convertOne(16'd40320);
    convertOne(16'd65535);
    convertOne(16'd0);
    convertOne(16'd5040);
    repeat (5) convertOne(W'($urandom_range(0, 65535)));

    heldHigh(16'd120);
    ignoredEdge(16'd1234, 16'd9999, 5);
    ignoredEdge(16'd720, 16'd8888, 16);
    resetMidConv(16'd31415);
    resetHeldValid(16'd777);
    convertOne(16'd777);
    convertOne(16'd42);

    repeat (3) @(negedge clk);
    checkOutput("sb_empty", 32'(expQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/fact_bin2bcd.md
FACT_BIN2BCD -- requirements
Module: fact_bin2bcd

Interface
REQ-001 Parameter W, default 16, SHALL set the binary input width and match the factorial result width.
REQ-002 Parameter D, default 5, SHALL set the number of BCD output digits; 10^D > 2^W-1 is required and SHALL be checked at elaboration.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 in_valid  input  1  SHALL indicate that bin_in holds a result; it is driven by the factorial block's done level.
REQ-006 bin_in  input  W  SHALL carry the unsigned binary value to convert; it is driven by the factorial block's fact output.
REQ-007 bcd_out  output  4*D  SHALL be the registered packed BCD result, with digit 0 (units) in bits [3:0].
REQ-008 bcd_valid  output  1  SHALL pulse high for one cycle when bcd_out is updated.
REQ-009 busy  output  1  SHALL be high while a conversion is in progress.

Function
REQ-010 The block SHALL register in_valid each cycle; capture occurs only on a rising edge (in_valid=1, previous=0), so a held done level is converted once.
REQ-011 The FSM SHALL have states IDLE and CONV; on a rising edge detected in IDLE it SHALL load bin_in into the shift register, clear the BCD scratch and count, and go to CONV.
REQ-012 Each CONV cycle SHALL perform one double-dabble step: add 3 to every scratch digit >=5, then shift {scratch, shift register} left by one.
REQ-013 After exactly W CONV cycles the FSM SHALL write the scratch to bcd_out, assert bcd_valid for that one cycle, and return to IDLE.
REQ-014 Latency: with capture at edge E0, bcd_out/bcd_valid SHALL update at edge E0+W (16 cycles by default).
REQ-015 busy SHALL equal (state==CONV) and be registered-derived, with no combinational path from in_valid.
REQ-016 A rising edge of in_valid while busy SHALL be ignored; the current conversion is unaffected, and the edge detector still tracks in_valid.
REQ-017 A rising edge in the same cycle as completion SHALL be ignored, because the state is CONV in that cycle.
REQ-018 bcd_out SHALL hold its last value between conversions and SHALL NOT change on ignored edges.
REQ-019 The bit counter SHALL be $clog2(W+1) bits wide and SHALL NOT wrap within a conversion.

Reset
REQ-020 Reset SHALL force state=IDLE, bcd_out=0, bcd_valid=0, busy=0, edge register=0, and scratch/shift/count=0.
REQ-021 Reset asserted mid-conversion SHALL abort it; no bcd_valid pulse SHALL occur for the aborted value.
REQ-022 If in_valid is held high through reset release, it SHALL NOT be captured until it falls and rises again.

Configuration
REQ-023 With BCD_BLANK_EN defined, an output blank[D-1:0] SHALL be present and registered with bcd_out; blank[i]=1 iff digit i and all higher digits are zero, and blank[0] is always 0. Reset value SHALL be 0.
REQ-024 Without BCD_BLANK_EN, the blank port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-025 Package fact_pkg SHALL hold the state typedef (IDLE, CONV), the default W/D constants and the nibble-width constant, shared with the factorial block.
REQ-026 The per-digit add-3 SHALL be a combinational sub-module bcd_adj3 (4-bit in, 4-bit out), instantiated D times.

Verification
REQ-027 in_valid rises with bin_in=24 -> busy for 16 cycles, bcd_valid pulse, bcd_out=0x00024.
REQ-028 bin_in=40320 (8!) -> bcd_out=0x40320; bin_in=65535 -> 0x65535; bin_in=0 -> 0x00000 with bcd_valid still pulsed.
REQ-029 in_valid held high for 40 cycles -> exactly one bcd_valid pulse; a second rising edge at cycle 5 of CONV -> ignored, result unchanged.
REQ-030 reset asserted at CONV cycle 8 -> no bcd_valid, bcd_out=0, busy=0 next cycle; a new edge then converts normally.
REQ-031 With BCD_BLANK_EN, bin_in=24 -> blank=5'b11100; bin_in=0 -> blank=5'b11110.
